// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg: shared constants and helpers for the pipelined binary/Gray codec.
//   MODE_ENC / MODE_DEC : per-word conversion direction carried alongside the data.
//   gc_nstages()        : pipeline depth for a given data width and chunk size.
package gray_codec_pkg;

    localparam logic MODE_ENC = 1'b0;  // binary -> Gray
    localparam logic MODE_DEC = 1'b1;  // Gray -> binary

    // Ceiling division: number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int unsigned gc_nstages(input int unsigned width,
                                               input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// gray_codec_stage: one pipeline slot of the Gray codec.
//   Stage K resolves decode bits [WIDTH-1-K*CHUNK : max(0, WIDTH-(K+1)*CHUNK)], seeded by
//   the lowest bit already resolved upstream. Stage 0 also performs the full encode.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   stall                  hold register contents this cycle
//   in_valid/mode/data     word arriving from the previous stage (or the block input)
//   out_valid/mode/data    registered word handed to the next stage (or the block output)
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    localparam int HI     = int'(WIDTH) - 1 - int'(K) * int'(CHUNK);
    localparam int LO_RAW = int'(WIDTH) - (int'(K) + 1) * int'(CHUNK);
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic             valid_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] word_d;
    logic             acc;

    // Bits above HI are already binary; bits in [HI:LO] are resolved here; bits below LO
    // stay raw Gray for later stages. acc tracks the binary value of the bit just above i.
    always_comb begin
        word_d = in_data;
        acc    = 1'b0;
        if (in_mode == MODE_DEC) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (i > HI) begin
                    acc = in_data[i];
                end else if (i >= LO) begin
                    acc       = acc ^ in_data[i];
                    word_d[i] = acc;
                end
            end
        end else if (K == 0) begin
            word_d = in_data ^ (in_data >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_ENC;
            data_q  <= '0;
        end else if (!stall) begin
            valid_q <= in_valid;
            mode_q  <= in_mode;
            data_q  <= word_d;
        end
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gray_codec.sv
// gray_codec: pipelined binary<->Gray converter with a valid/ready stream interface.
//   Latency NSTAGES = ceil(WIDTH/CHUNK) cycles, one word per cycle, strict FIFO order,
//   mode selectable per word. The whole pipe freezes while the output is stalled.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid, in_ready               input handshake (in_ready is combinational)
//   in_mode, in_data                 0 = encode, 1 = decode; word to convert
//   out_valid, out_ready             output handshake
//   out_mode, out_data               registered mode and converted word
module gray_codec
    import gray_codec_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned NSTAGES = gc_nstages(WIDTH, CHUNK);

    // Index k feeds stage k; index NSTAGES is the last stage's register.
    logic             valid_s [0:NSTAGES];
    logic             mode_s  [0:NSTAGES];
    logic [WIDTH-1:0] data_s  [0:NSTAGES];
    logic             stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign valid_s[0] = in_valid;
    assign mode_s[0]  = in_mode;
    assign data_s[0]  = in_data;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        gray_codec_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stall     (stall),
            .in_valid  (valid_s[k]),
            .in_mode   (mode_s[k]),
            .in_data   (data_s[k]),
            .out_valid (valid_s[k+1]),
            .out_mode  (mode_s[k+1]),
            .out_data  (data_s[k+1])
        );
    end

    assign out_valid = valid_s[NSTAGES];
    assign out_mode  = mode_s[NSTAGES];
    assign out_data  = data_s[NSTAGES];

endmodule

// File: tb/tb_gray_codec.sv
// tb_gray_codec: directed bench for gray_codec at WIDTH=8/CHUNK=4 and WIDTH=5/CHUNK=2.
module tb_gray_codec;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [7:0] a_in_data, a_out_data;

    logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [4:0] b_in_data, b_out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_codec #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_mode   (a_in_mode),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_mode  (a_out_mode),
        .out_data  (a_out_data)
    );

    gray_codec #(.WIDTH(5), .CHUNK(2)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_mode   (b_in_mode),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_mode  (b_out_mode),
        .out_data  (b_out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic v, input logic m, input logic [7:0] d);
        a_in_valid = v;
        a_in_mode  = m;
        a_in_data  = d;
    endtask

    // Single isolated transfer on the 8-bit instance: accept, then result after 2nd edge.
    task automatic xfer8(input string tag, input logic m, input logic [7:0] d,
                         input logic [7:0] exp);
        drive8(1'b1, m, d);
        tick();
        drive8(1'b0, 1'b0, 8'h00);
        check({tag, "_early"}, {31'd0, a_out_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, a_out_data}, {24'd0, exp});
        check({tag, "_mode"}, {31'd0, a_out_mode}, {31'd0, m});
        tick();
    endtask

    logic [4:0] enc_vals [32];
    logic [4:0] dec_vals [32];
    int         idx;

    initial begin
        rst_n = 1'b0;
        drive8(1'b0, 1'b0, 8'h00);
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_mode   = 1'b0;
        b_in_data   = 5'd0;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data", {24'd0, a_out_data}, 32'd0);
        check("rst_out_mode", {31'd0, a_out_mode}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst5_out_valid", {31'd0, b_out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfers incl. wrap values
        xfer8("enc_b6", 1'b0, 8'hB6, 8'hED);
        xfer8("dec_ed", 1'b1, 8'hED, 8'hB6);
        xfer8("dec_80", 1'b1, 8'h80, 8'hFF);
        xfer8("enc_ff", 1'b0, 8'hFF, 8'h80);

        // Back-to-back alternating modes
        drive8(1'b1, 1'b0, 8'h00); tick();
        check("b2b_lat", {31'd0, a_out_valid}, 32'd0);
        drive8(1'b1, 1'b1, 8'h01); tick();
        check("b2b0_v", {31'd0, a_out_valid}, 32'd1);
        check("b2b0_d", {24'd0, a_out_data}, 32'h00);
        check("b2b0_m", {31'd0, a_out_mode}, 32'd0);
        drive8(1'b1, 1'b0, 8'h02); tick();
        check("b2b1_v", {31'd0, a_out_valid}, 32'd1);
        check("b2b1_d", {24'd0, a_out_data}, 32'h01);
        check("b2b1_m", {31'd0, a_out_mode}, 32'd1);
        drive8(1'b1, 1'b1, 8'h03); tick();
        check("b2b2_v", {31'd0, a_out_valid}, 32'd1);
        check("b2b2_d", {24'd0, a_out_data}, 32'h03);
        check("b2b2_m", {31'd0, a_out_mode}, 32'd0);
        drive8(1'b0, 1'b0, 8'h00); tick();
        check("b2b3_v", {31'd0, a_out_valid}, 32'd1);
        check("b2b3_d", {24'd0, a_out_data}, 32'h02);
        check("b2b3_m", {31'd0, a_out_mode}, 32'd1);
        tick();
        check("b2b_drain", {31'd0, a_out_valid}, 32'd0);

        // Backpressure: A=enc 0x10->0x18, B=dec 0x10->0x1F, C=enc 0x55->0x7F
        a_out_ready = 1'b0;
        drive8(1'b1, 1'b0, 8'h10); tick();
        drive8(1'b1, 1'b1, 8'h10); tick();
        drive8(1'b1, 1'b0, 8'h55);
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            check("bp_valid", {31'd0, a_out_valid}, 32'd1);
            check("bp_data", {24'd0, a_out_data}, 32'h18);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        drive8(1'b0, 1'b0, 8'h00);
        check("bp_b_v", {31'd0, a_out_valid}, 32'd1);
        check("bp_b_d", {24'd0, a_out_data}, 32'h1F);
        check("bp_b_m", {31'd0, a_out_mode}, 32'd1);
        tick();
        check("bp_c_v", {31'd0, a_out_valid}, 32'd1);
        check("bp_c_d", {24'd0, a_out_data}, 32'h7F);
        check("bp_c_m", {31'd0, a_out_mode}, 32'd0);
        tick();
        check("bp_nodup", {31'd0, a_out_valid}, 32'd0);

        // Reset mid-stream: one word inside, a second offered in the reset cycle
        drive8(1'b1, 1'b0, 8'h33); tick();
        drive8(1'b1, 1'b0, 8'h44);
        rst_n = 1'b0;
        tick();
        check("mrst_valid", {31'd0, a_out_valid}, 32'd0);
        check("mrst_data", {24'd0, a_out_data}, 32'd0);
        check("mrst_mode", {31'd0, a_out_mode}, 32'd0);
        rst_n = 1'b1;
        drive8(1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mrst_gone", {31'd0, a_out_valid}, 32'd0);
        end

        // Exhaustive encode sweep on the 5-bit, 3-stage instance
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            b_in_valid = (c < 32);
            b_in_mode  = 1'b0;
            b_in_data  = 5'(c);
            tick();
            if (b_out_valid && idx < 32) begin
                check("sw_enc_mode", {31'd0, b_out_mode}, 32'd0);
                enc_vals[idx] = b_out_data;
                idx++;
            end
        end
        check("sw_enc_count", idx, 32);
        b_in_valid = 1'b0;

        // Latency of the 3-stage instance, then decode sweep
        b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = 5'h10; tick();
        b_in_valid = 1'b0;
        tick();
        check("lat5_e2", {31'd0, b_out_valid}, 32'd0);
        tick();
        check("lat5_e3_v", {31'd0, b_out_valid}, 32'd1);
        check("lat5_e3_d", {27'd0, b_out_data}, 32'h1F);
        tick();

        idx = 0;
        for (int c = 0; c < 40; c++) begin
            b_in_valid = (c < 32);
            b_in_mode  = 1'b1;
            b_in_data  = (c < 32) ? enc_vals[c] : 5'd0;
            tick();
            if (b_out_valid && idx < 32) begin
                check("sw_dec_mode", {31'd0, b_out_mode}, 32'd1);
                dec_vals[idx] = b_out_data;
                idx++;
            end
        end
        check("sw_dec_count", idx, 32);
        b_in_valid = 1'b0;

        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            check("sw_enc_val", {27'd0, enc_vals[i]}, {27'd0, v ^ (v >> 1)});
            check("sw_roundtrip", {27'd0, dec_vals[i]}, {27'd0, v});
            check("sw_onebit", $countones(enc_vals[i] ^ enc_vals[(i + 1) % 32]), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
